// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU response checker: data width, FSM states,
// mismatch-mask bit positions and the packed ALU response record.
package alu_pkg;

    localparam int ALU_W = 16;
    localparam int MM_W  = 6;

    localparam int MM_Z    = 5;
    localparam int MM_S    = 4;
    localparam int MM_ZERO = 3;
    localparam int MM_C    = 2;
    localparam int MM_P    = 1;
    localparam int MM_V    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ALU_W-1:0] z;
        logic             sign;
        logic             zero;
        logic             carry;
        logic             parity;
        logic             overflow;
    } alu_resp_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected ALU response for an add of x and y (result plus five flags).
// Reusable by any bench that needs the golden ALU answer.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    output alu_resp_t        expected
);

    logic [ALU_W:0] sum;

    assign sum = {1'b0, x} + {1'b0, y};

    always_comb begin
        expected          = '0;
        expected.z        = sum[ALU_W-1:0];
        expected.carry    = sum[ALU_W];
        expected.sign     = sum[ALU_W-1];
        expected.zero     = (sum[ALU_W-1:0] == '0);
        expected.parity   = ~^sum[ALU_W-1:0];
        // Overflow: operands share a sign that the result does not.
        expected.overflow = (x[ALU_W-1] & y[ALU_W-1] & ~sum[ALU_W-1]) |
                            (~x[ALU_W-1] & ~y[ALU_W-1] & sum[ALU_W-1]);
    end

endmodule

// File: rtl/alu_checker.sv
// ALU response checker: two-stage compare pipeline plus run statistics under a start/stop FSM.
// First-error capture is built only when ALU_CHECKER_FIRST_ERR_EN is defined.
module alu_checker
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    input  logic [ALU_W-1:0] z,
    input  logic             sign,
    input  logic             zero,
    input  logic             carry,
    input  logic             parity,
    input  logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ALU_W-1:0] txn_count,
    output logic [ALU_W-1:0] err_count,
    output logic [ALU_W-1:0] first_err_idx,
    output logic [MM_W-1:0]  first_err_mask
);

    state_t           state;
    logic             s1_valid;
    logic [ALU_W-1:0] s1_x;
    logic [ALU_W-1:0] s1_y;
    alu_resp_t        s1_obs;
    logic             s2_valid;
    logic [MM_W-1:0]  s2_vec;
    alu_resp_t        ref_resp;
    logic [MM_W-1:0]  vec;
    logic             start_run;
    logic             s2_fail;

    alu_ref_model u_ref (
        .x        (s1_x),
        .y        (s1_y),
        .expected (ref_resp)
    );

    always_comb begin
        vec          = '0;
        vec[MM_Z]    = (s1_obs.z != ref_resp.z);
        vec[MM_S]    = (s1_obs.sign != ref_resp.sign);
        vec[MM_ZERO] = (s1_obs.zero != ref_resp.zero);
        vec[MM_C]    = (s1_obs.carry != ref_resp.carry);
        vec[MM_P]    = (s1_obs.parity != ref_resp.parity);
        vec[MM_V]    = (s1_obs.overflow != ref_resp.overflow);
    end

    assign start_run = start && ((state == IDLE) || (state == DONE));
    assign s2_fail   = s2_valid && (s2_vec != '0);
    assign pass      = done && (err_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            txn_count <= '0;
            err_count <= '0;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_obs    <= '0;
            s2_valid  <= 1'b0;
            s2_vec    <= '0;
        end else begin
            mismatch <= 1'b0;
            s1_valid <= (state == CHECK) && in_valid;
            s1_x     <= x;
            s1_y     <= y;
            s1_obs   <= '{z: z, sign: sign, zero: zero, carry: carry,
                          parity: parity, overflow: overflow};
            s2_valid <= s1_valid;
            s2_vec   <= vec;

            if (s2_valid) begin
                if (txn_count != '1)
                    txn_count <= txn_count + 1'b1;
                if (s2_fail) begin
                    mismatch <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start_run) begin
                        state     <= CHECK;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        txn_count <= '0;
                        err_count <= '0;
                        s1_valid  <= 1'b0;
                        s2_valid  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (stop)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Stage 2 retires its sample on this same edge, so stage 1 empty is enough.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if (start_run) begin
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if (s2_fail && (err_count == '0)) begin
            first_err_idx  <= txn_count;
            first_err_mask <= s2_vec;
        end
    end
`else
    assign first_err_idx  = '0;
    assign first_err_mask = '0;
`endif

endmodule

// File: doc/alu_checker.md
# alu_checker

Synthesizable response checker for the 16-bit ALU: the receiving end of the ALU stimulus stream. It accepts each operand pair together with the ALU's result and flags (X, Y, Z, sign, zero, carry, parity, overflow). It recomputes the expected values in a two-stage pipeline, compares them, and keeps transaction and error statistics across a start/stop-delimited run. It sits beside the ALU in self-checking benches and in on-chip BIST wrappers.

## Interface
- No parameters. Data width is fixed at 16 by the shared package.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse: clear statistics and begin a run. Honoured in IDLE or DONE only.
- stop  in  1  pulse: end the run. Honoured in CHECK only.
- in_valid  in  1  the sample on the data inputs is valid this cycle.
- x, y  in  16  ALU operands.
- z  in  16  ALU result.
- sign, zero, carry, parity, overflow  in  1 each  ALU flags.
- busy  out  1  high in CHECK or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count == 0.
- mismatch  out  1  one-cycle pulse per failing sample.
- txn_count  out  16  number of samples checked; saturates at 16'hFFFF.
- err_count  out  16  number of failing samples; saturates at 16'hFFFF.
- first_err_idx  out  16  txn index (0-based) of the first failing sample.
- first_err_mask  out  6  mismatch bits of the first failure: {z, sign, zero, carry, parity, overflow}.

## Operation
- Expected model: {c, e} = x + y as a 17-bit sum.
  - ez = e[15:0]; ec = c.
  - es = e[15]; ezero = (ez == 0); ep = ~^ez (1 = even number of ones).
  - ev = (x[15] & y[15] & ~e[15]) | (~x[15] & ~y[15] & e[15]).
- FSM states: IDLE, CHECK, DRAIN, DONE.
  - IDLE -start-> CHECK.
  - CHECK -stop-> DRAIN.
  - DRAIN -> DONE once both pipeline stages are empty.
  - DONE -start-> CHECK.
- On entering CHECK: txn_count, err_count, first_err_idx and first_err_mask clear to 0; pipeline valids clear.
- Samples are accepted only in CHECK. in_valid is ignored in IDLE, DRAIN and DONE.
- If stop and in_valid arrive in the same cycle, that sample is accepted.
- Stage 1 registers the inputs and the valid bit.
- Stage 2 computes the 6-bit mismatch vector. A sample fails if the vector is non-zero. On stage-2 valid:
  - txn_count increments (saturating).
  - On failure: mismatch pulses and err_count increments (saturating).
  - On the first failure of the run: first_err_idx ← current txn_count value and first_err_mask ← vector. Both are then frozen for the rest of the run.
- start in CHECK/DRAIN and stop outside CHECK are ignored.
- Statistics hold their values in DONE until the next start.

## Timing
- Throughput: one sample per cycle. There is no backpressure, so the checker is always ready.
- Latency: a sample accepted at edge N updates counters and pulses mismatch at edge N+2.
- DRAIN lasts at most 2 cycles. done rises 1–3 cycles after stop.
- Reset values:
  - state = IDLE.
  - All outputs 0: busy, done, pass, mismatch, txn_count, err_count, first_err_idx, first_err_mask.
  - Pipeline valids 0.
- Reset asserted mid-run aborts the run immediately. No partial statistics survive.
- Saturation: at 16'hFFFF each counter holds its value. first_err_idx captured after txn_count has saturated reads 16'hFFFF.

## Configuration
- ALU_CHECKER_FIRST_ERR_EN
  - Defined: first-error capture logic is built as described above.
  - Undefined: the capture registers are omitted, and first_err_idx and first_err_mask are tied to 0. Counters, mismatch and pass are unchanged.

## Structure
- Package alu_pkg holds:
  - ALU_W = 16.
  - The FSM state enum (IDLE, CHECK, DRAIN, DONE).
  - The mismatch-mask bit-position constants (MM_Z = 5 … MM_V = 0).
- One sub-module, alu_ref_model: purely combinational expected-value computation from x and y. It is reusable by other ALU benches.

## Test plan
- **Reset defaults:** rst high mid-run → all outputs 0 and state IDLE. in_valid pulses afterwards leave txn_count at 0.
- **Clean run:** start; feed these three samples back-to-back, then stop:
  - 8fff+8000 → z=0fff, carry=1, overflow=1, parity=1, sign=0, zero=0.
  - fffe+0002 → z=0000, carry=1, zero=1, parity=1, sign=0, overflow=0.
  - AAAA+5555 → z=FFFF, sign=1, parity=1, carry=0, overflow=0, zero=0.
  - Required: txn_count=3, err_count=0, and done with pass=1 within 3 cycles of stop.
- **Flag error:** same run, but the second sample has carry=0 → mismatch pulses exactly 2 cycles after acceptance; err_count=1, first_err_idx=1, first_err_mask=6'b000100, pass=0.
- **Multiple errors:** sample 0 has z=1000 and sample 2 has parity=0 → err_count=2, first_err_idx=0, first_err_mask=6'b100000 (frozen).
- **Boundary handshakes:**
  - stop together with in_valid → that sample is counted.
  - in_valid in DONE → ignored.
  - start in CHECK → ignored; a new start in DONE clears all statistics.
- **Saturation (macro on and off):** force txn_count near the top and feed 2 samples → txn_count holds at FFFF. With the macro undefined, the first-error outputs stay 0 despite failures.
